// File: rtl/cpu_controller.sv
// Four-state instruction sequencer for a small register-bus datapath (IDLE/T1/T2/T3).
// Optional retired-instruction counter is built only when CPU_CTRL_INSTR_COUNT_EN is defined.
module cpu_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [27:0]      instr,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [9:0]       r_en_OH,
  output logic [9:0]       tri_controller_OH,
  output logic [22:0]      code,
  output logic [CNT_W-1:0] instr_count,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

  localparam logic [2:0] CLS_MV     = 3'b000;
  localparam logic [2:0] CLS_MVI    = 3'b001;
  localparam logic [2:0] CLS_ALU_R  = 3'b010;
  localparam logic [2:0] CLS_ALU_I  = 3'b011;
  localparam logic [3:0] IDX_G      = 4'd8;
  localparam logic [3:0] IDX_A_IMM  = 4'd9;

  state_t      state_q, state_d;
  logic [27:0] ir_q, ir_d;

  logic [2:0]  cls;
  logic [2:0]  alu_op;
  logic [2:0]  rx;
  logic [2:0]  ry;
  logic [15:0] imm;

  assign cls    = ir_q[27:25];
  assign alu_op = ir_q[24:22];
  assign rx     = ir_q[21:19];
  assign ry     = ir_q[18:16];
  assign imm    = ir_q[15:0];

  assign ready       = (state_q == IDLE);
  assign dbg_state_o = state_q;

  function automatic logic [9:0] sel(input logic [3:0] idx);
    sel = 10'd1 << idx;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs come only from state_q and ir_q, so a live instr change mid-flight is invisible.
  always_comb begin
    state_d           = state_q;
    ir_d              = ir_q;
    r_en_OH           = '0;
    tri_controller_OH = '0;
    code              = '0;
    done              = 1'b0;
    err               = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ir_d    = instr;
          state_d = T1;
        end
      end
      T1: begin
        code = {alu_op, 4'b0000, imm};
        case (cls)
          CLS_MV: begin
            tri_controller_OH = sel({1'b0, ry});
            r_en_OH           = sel({1'b0, rx});
            done              = 1'b1;
            state_d           = IDLE;
          end
          CLS_MVI: begin
            tri_controller_OH = sel(IDX_A_IMM);
            r_en_OH           = sel({1'b0, rx});
            done              = 1'b1;
            state_d           = IDLE;
          end
          CLS_ALU_R, CLS_ALU_I: begin
            tri_controller_OH = sel({1'b0, rx});
            r_en_OH           = sel(IDX_A_IMM);
            state_d           = T2;
          end
          default: begin
            done    = 1'b1;
            err     = 1'b1;
            state_d = IDLE;
          end
        endcase
      end
      T2: begin
        code              = {alu_op, 4'b0000, imm};
        tri_controller_OH = (cls == CLS_ALU_I) ? sel(IDX_A_IMM) : sel({1'b0, ry});
        r_en_OH           = sel(IDX_G);
        state_d           = T3;
      end
      T3: begin
        code              = {alu_op, 4'b0000, imm};
        tri_controller_OH = sel(IDX_G);
        r_en_OH           = sel({1'b0, rx});
        done              = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CPU_CTRL_INSTR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (done && !err) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed scenarios plus random traffic
// compared each cycle against a per-instruction expected-cycle queue.
module tb_cpu_controller;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [27:0]      instr;
  logic             ready;
  logic             done;
  logic             err;
  logic [9:0]       r_en_OH;
  logic [9:0]       tri_controller_OH;
  logic [22:0]      code;
  logic [CNT_W-1:0] instr_count;
  logic [1:0]       dbg_state;

  int n_vec;
  int n_fail;

  // Each entry is one expected busy cycle: {tri, r_en, code, done, err}.
  logic [44:0]      exp_q[$];
  logic [CNT_W-1:0] exp_cnt;

  cpu_controller #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .instr             (instr),
    .ready             (ready),
    .done              (done),
    .err               (err),
    .r_en_OH           (r_en_OH),
    .tri_controller_OH (tri_controller_OH),
    .code              (code),
    .instr_count       (instr_count),
    .dbg_state_o       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [27:0] mk(input logic [2:0] cls, input logic [2:0] op,
                                     input logic [2:0] rx, input logic [2:0] ry,
                                     input logic [15:0] imm);
    mk = {cls, op, rx, ry, imm};
  endfunction

  function automatic logic [44:0] ent(input int t, input int r, input logic [22:0] c,
                                      input logic d, input logic e);
    logic [9:0] tv;
    logic [9:0] rv;
    tv = (t < 0) ? 10'd0 : (10'd1 << t);
    rv = (r < 0) ? 10'd0 : (10'd1 << r);
    ent = {tv, rv, c, d, e};
  endfunction

  // Reference: expand one accepted instruction into its list of busy cycles.
  task automatic push_seq(input logic [27:0] in);
    int cls, rx, ry;
    logic [22:0] c;
    cls = int'(in[27:25]);
    rx  = int'(in[21:19]);
    ry  = int'(in[18:16]);
    c   = {in[24:22], 4'b0000, in[15:0]};
    case (cls)
      0: exp_q.push_back(ent(ry, rx, c, 1'b1, 1'b0));
      1: exp_q.push_back(ent(9, rx, c, 1'b1, 1'b0));
      2, 3: begin
        exp_q.push_back(ent(rx, 9, c, 1'b0, 1'b0));
        exp_q.push_back(ent((cls == 2) ? ry : 9, 8, c, 1'b0, 1'b0));
        exp_q.push_back(ent(8, rx, c, 1'b1, 1'b0));
      end
      default: exp_q.push_back(ent(-1, -1, c, 1'b1, 1'b1));
    endcase
  endtask

  task automatic model_edge(input logic r, input logic s, input logic [27:0] in);
    logic [44:0] e;
    if (!r) begin
      exp_q.delete();
      exp_cnt = '0;
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
`ifdef CPU_CTRL_INSTR_COUNT_EN
      if (e[1] && !e[0]) exp_cnt = exp_cnt + 1'b1;
`else
      if (e[1] && !e[0]) exp_cnt = '0;
`endif
    end else if (s) begin
      push_seq(in);
    end
  endtask

  task automatic check_outputs();
    logic [44:0] e;
    e = (exp_q.size() == 0) ? 45'd0 : exp_q[0];
    check_eq("ready", ready, (exp_q.size() == 0));
    check_eq("tri", tri_controller_OH, e[44:35]);
    check_eq("r_en", r_en_OH, e[34:25]);
    check_eq("code", code, e[24:2]);
    check_eq("done", done, e[1]);
    check_eq("err", err, e[0]);
    check_eq("count", instr_count, exp_cnt);
    check_eq("tri_onehot", ($countones(tri_controller_OH) <= 1), 1);
    check_eq("r_en_onehot", ($countones(r_en_OH) <= 1), 1);
  endtask

  // driver: called at a falling edge; checks, drives the next edge's inputs, advances.
  task automatic cycle(input logic r, input logic s, input logic [27:0] in);
    check_outputs();
    rst_n = r;
    start = s;
    instr = in;
    model_edge(r, s, in);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec   = 0;
    n_fail  = 0;
    exp_cnt = '0;
    rst_n   = 1'b0;
    start   = 1'b0;
    instr   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    cycle(1'b1, 1'b0, 28'd0);

    // MVI R3, 0x00A5
    cycle(1'b1, 1'b1, mk(3'b001, 3'b000, 3'd3, 3'd0, 16'h00A5));
    check_eq("mvi_tri", tri_controller_OH, 10'h200);
    check_eq("mvi_r_en", r_en_OH, 10'h008);
    check_eq("mvi_code", code, 23'h0000A5);
    check_eq("mvi_done", done, 1'b1);
    cycle(1'b1, 1'b0, 28'd0);
    check_eq("mvi_ready_back", ready, 1'b1);

    // MV R1, R6
    cycle(1'b1, 1'b1, mk(3'b000, 3'b000, 3'd1, 3'd6, 16'h1234));
    check_eq("mv_tri", tri_controller_OH, 10'h040);
    check_eq("mv_r_en", r_en_OH, 10'h002);
    check_eq("mv_done", done, 1'b1);
    cycle(1'b1, 1'b0, 28'd0);

    // ALU register op=010, R2, R5
    cycle(1'b1, 1'b1, mk(3'b010, 3'b010, 3'd2, 3'd5, 16'h0000));
    check_eq("alu_t1", {tri_controller_OH, r_en_OH}, {10'h004, 10'h200});
    check_eq("alu_t1_op", code[22:20], 3'b010);
    check_eq("alu_t1_done", done, 1'b0);
    cycle(1'b1, 1'b0, 28'd0);
    check_eq("alu_t2", {tri_controller_OH, r_en_OH}, {10'h020, 10'h100});
    check_eq("alu_t2_op", code[22:20], 3'b010);
    check_eq("alu_t2_done", done, 1'b0);
    cycle(1'b1, 1'b0, 28'd0);
    check_eq("alu_t3", {tri_controller_OH, r_en_OH}, {10'h100, 10'h004});
    check_eq("alu_t3_op", code[22:20], 3'b010);
    check_eq("alu_t3_done", done, 1'b1);
    cycle(1'b1, 1'b0, 28'd0);

    // start held high with instr changing every cycle while busy
    cycle(1'b1, 1'b1, mk(3'b011, 3'b101, 3'd4, 3'd4, 16'hBEEF));
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 28'($urandom));
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 28'd0);

    // illegal class 101
    cycle(1'b1, 1'b1, mk(3'b101, 3'b111, 3'd7, 3'd2, 16'hFFFF));
    check_eq("ill_done_err", {done, err}, 2'b11);
    check_eq("ill_en", {tri_controller_OH, r_en_OH}, 20'd0);
    cycle(1'b1, 1'b0, 28'd0);

    // reset asserted in T2 of an ALU instruction, with start high
    cycle(1'b1, 1'b1, mk(3'b010, 3'b001, 3'd0, 3'd7, 16'h0F0F));
    cycle(1'b1, 1'b0, 28'd0);
    cycle(1'b0, 1'b1, mk(3'b001, 3'b000, 3'd1, 3'd0, 16'h5555));
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_en", {tri_controller_OH, r_en_OH}, 20'd0);
    check_eq("rst_code", code, 23'd0);
    cycle(1'b1, 1'b0, 28'd0);

    // counter wrap: 2^CNT_W + 1 MVIs after reset
    cycle(1'b0, 1'b0, 28'd0);
    for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
      cycle(1'b1, 1'b1, mk(3'b001, 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom)));
      cycle(1'b1, 1'b0, 28'd0);
    end
`ifdef CPU_CTRL_INSTR_COUNT_EN
    check_eq("cnt_wrap", instr_count, 1);
`else
    check_eq("cnt_wrap", instr_count, 0);
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)), 28'($urandom));
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 28'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port start  input  1  request to execute instr.
REQ-005 The block SHALL have port instr  input  28  instruction: [27:25] class, [24:22] alu_op, [21:19] rx, [18:16] ry, [15:0] imm.
REQ-006 The block SHALL have port ready  output  1  high when idle and able to accept an instruction.
REQ-007 The block SHALL have port done  output  1  high in the final execution cycle of an instruction.
REQ-008 The block SHALL have port err  output  1  high with done when the latched class is illegal.
REQ-009 The block SHALL have port r_en_OH  output  10  register write enables: bits 0-7 R0-R7, bit 8 G, bit 9 A.
REQ-010 The block SHALL have port tri_controller_OH  output  10  bus drivers: bits 0-7 R0-R7, bit 8 G, bit 9 immediate.
REQ-011 The block SHALL have port code  output  23  datapath code: [22:20] alu_op, [19:16] zero, [15:0] imm.
REQ-012 The block SHALL have port instr_count  output  CNT_W  retired-instruction count.

Function
REQ-013 The FSM SHALL have the states IDLE, T1, T2 and T3; ready SHALL be high only in IDLE.
REQ-014 In IDLE with start=1, the block SHALL latch instr into an internal register and move to T1 on that edge.
REQ-015 All outputs SHALL derive from the state and the latched instruction, never from the live instr input.
REQ-016 start SHALL be ignored outside IDLE, and a change on instr SHALL have no effect while the FSM is busy.
REQ-017 In IDLE, r_en_OH, tri_controller_OH, code, done and err SHALL all be 0.
REQ-018 Class 000 (MV) SHALL use T1 only: tri[ry]=1, r_en[rx]=1, done=1, then return to IDLE.
REQ-019 Class 001 (MVI) SHALL use T1 only: tri[9]=1, r_en[rx]=1, done=1, then return to IDLE.
REQ-020 Class 010 (ALU register) SHALL run T1: tri[rx], r_en[9]; then T2: tri[ry], r_en[8]; then T3: tri[8], r_en[rx], done=1; then return to IDLE.
REQ-021 Class 011 (ALU immediate) SHALL follow the class 010 sequence, except that T2 drives tri[9] instead of tri[ry].
REQ-022 code[22:20] SHALL equal the latched alu_op and code[15:0] SHALL equal the latched imm in every non-IDLE state.
REQ-023 Classes 100-111 SHALL take T1 only with all enables 0 and done=1, err=1, then return to IDLE.
REQ-024 At most one bit of tri_controller_OH SHALL be high in any cycle, and at most one bit of r_en_OH SHALL be high in any cycle.
REQ-025 When rx equals ry, the sequences SHALL be unchanged; MV Rx,Rx is a legal one-cycle no-op write.
REQ-026 A new instruction SHALL NOT be accepted in a done cycle; it is accepted no earlier than the following IDLE cycle.
REQ-027 Latency from the accept edge to done SHALL be 1 cycle for MV, MVI and illegal classes, and 3 cycles for ALU classes.

Reset
REQ-028 While rst_n is sampled low, the FSM SHALL go to IDLE on that edge, with the instruction register 0 and instr_count 0.
REQ-029 Reset asserted in mid-operation SHALL abort the instruction with no further write enables and no done pulse.
REQ-030 start SHALL be ignored on any edge where rst_n is low.

Configuration
REQ-031 With macro CPU_CTRL_INSTR_COUNT_EN defined, instr_count SHALL increment by 1 on each edge where done=1 and err=0, wrapping modulo 2^CNT_W.
REQ-032 Without CPU_CTRL_INSTR_COUNT_EN, instr_count SHALL be constant 0 and the block SHALL contain no counter flops.

Verification
REQ-033 After reset, MVI class with rx=3 and imm=16'h00A5: next cycle tri=10'h200, r_en=10'h008, code=23'h0000A5, done=1; ready returns high the cycle after.
REQ-034 MV class with rx=1, ry=6: one cycle of tri=10'h040 and r_en=10'h002 with done=1.
REQ-035 ALU register class with alu_op=3'b010, rx=2, ry=5: the bench SHALL check (tri, r_en) = (004,200), then (020,100), then (100,004), with code[22:20]=010 throughout and done only in the third cycle.
REQ-036 Hold start=1 with a changing instr through an ALU instruction: only the first instr SHALL execute, and the next is accepted after done.
REQ-037 Class 101: one cycle with done=1, err=1, r_en=0 and tri=0; instr_count SHALL NOT increment.
REQ-038 Drive rst_n low in T2 of an ALU instruction: the next cycle SHALL be IDLE with all outputs 0 and no done; with the macro defined, 2^CNT_W+1 MVIs SHALL leave instr_count=1.
